// File: rtl/data_cache_pkg.sv
// -----------------------------------------------------------------------------
// data_cache_pkg
// Shared definitions for the direct-mapped, write-through data cache.
//   - state_e      : controller FSM states (IDLE, FILL, WRITE)
//   - OFFSET_WIDTH : byte-offset bits below the word index
//   - tag_width()  : tag width derived from address and index widths
// Optional feature macro used by the cache: DATA_CACHE_STATS_EN.
// -----------------------------------------------------------------------------
package data_cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_e;

    localparam int OFFSET_WIDTH = 2;

    // Tag is everything above the set index and the byte offset.
    function automatic int tag_width(input int addr_w, input int index_w);
        return addr_w - index_w - OFFSET_WIDTH;
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// -----------------------------------------------------------------------------
// data_cache_array
// Valid/tag/data storage for a direct-mapped cache, one word per set.
// Read side is combinational (hit + data), write side is synchronous.
// Ports:
//   clk_i, rst_ni      : clock, async active-low reset (clears valid bits only)
//   rd_index_i/tag_i   : lookup set and tag
//   hit_o              : set valid and stored tag matches
//   rdata_o            : stored word of the looked-up set
//   we_i               : write enable (sets valid, writes tag and data)
//   wr_index_i/tag_i   : set and tag to write
//   wr_data_i          : word to write
// -----------------------------------------------------------------------------
module data_cache_array #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH   = 26
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic [INDEX_WIDTH-1:0] rd_index_i,
    input  logic [TAG_WIDTH-1:0]   rd_tag_i,
    output logic                   hit_o,
    output logic [DATA_WIDTH-1:0]  rdata_o,
    input  logic                   we_i,
    input  logic [INDEX_WIDTH-1:0] wr_index_i,
    input  logic [TAG_WIDTH-1:0]   wr_tag_i,
    input  logic [DATA_WIDTH-1:0]  wr_data_i
);

    localparam int SETS = 2 ** INDEX_WIDTH;

    logic [SETS-1:0]       valid_q;
    logic [TAG_WIDTH-1:0]  tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else if (we_i) begin
            valid_q[wr_index_i] <= 1'b1;
        end
    end

    // Tag and data are qualified by valid, so they need no reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            tag_q[wr_index_i]  <= wr_tag_i;
            data_q[wr_index_i] <= wr_data_i;
        end
    end

    assign hit_o   = valid_q[rd_index_i] && (tag_q[rd_index_i] == rd_tag_i);
    assign rdata_o = data_q[rd_index_i];

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-through, no-write-allocate data cache for the memory
// stage of a pipeline. Read hits return data combinationally with no stall;
// read misses and all stores stall the pipeline while a single backing-memory
// transaction is performed.
// Ports:
//   clk_i, rst_ni          : clock, async active-low reset
//   rd_en_i, wr_en_i       : load / store request (both high = store)
//   addr_i, data_i         : byte address, store data
//   data_o                 : load data (0 unless a load hits in IDLE)
//   stall_o                : freeze upstream pipeline registers
//   mem_req_o, mem_we_o    : backing-memory request / write flag
//   mem_addr_o, mem_wdata_o: word-aligned request address, write data
//   mem_rdata_i, mem_ack_i : read data and one-cycle completion pulse
//   state_o                : controller state (debug visibility)
//   hit_cnt_o, miss_cnt_o  : saturating read hit/miss counters, present only
//                            when DATA_CACHE_STATS_EN is defined
// Memory handshake: the cache raises mem_req_o with stable mem_we_o,
// mem_addr_o and mem_wdata_o and holds them until the cycle in which
// mem_ack_i is high; that cycle completes the transaction and the request
// drops on the following edge. mem_ack_i outside FILL/WRITE is ignored.
// -----------------------------------------------------------------------------
module data_cache
    import data_cache_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  stall_o,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wdata_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_ack_i,
    output logic [1:0]            state_o
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt_o,
    output logic [31:0]           miss_cnt_o
`endif
);

    localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, INDEX_WIDTH);

    state_e                  state_q;
    logic                    done_q;
    logic                    mem_req_q;
    logic                    mem_we_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [DATA_WIDTH-1:0]   mem_wdata_q;

    logic [INDEX_WIDTH-1:0]  index;
    logic [TAG_WIDTH-1:0]    tag;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   line_data;
    logic                    arr_we;
    logic [DATA_WIDTH-1:0]   arr_wdata;
    logic                    load;

    assign index     = addr_i[INDEX_WIDTH+1:OFFSET_WIDTH];
    assign tag       = addr_i[ADDR_WIDTH-1:INDEX_WIDTH+OFFSET_WIDTH];
    assign word_addr = addr_i & ~ADDR_WIDTH'(3);
    assign load      = rd_en_i && !wr_en_i;

    // Fills always write the line; stores only refresh a line already present.
    assign arr_we    = mem_ack_i && ((state_q == FILL) || ((state_q == WRITE) && hit));
    assign arr_wdata = (state_q == FILL) ? mem_rdata_i : data_i;

    data_cache_array #(
        .DATA_WIDTH  (DATA_WIDTH),
        .INDEX_WIDTH (INDEX_WIDTH),
        .TAG_WIDTH   (TAG_WIDTH)
    ) u_array (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .rd_index_i (index),
        .rd_tag_i   (tag),
        .hit_o      (hit),
        .rdata_o    (line_data),
        .we_i       (arr_we),
        .wr_index_i (index),
        .wr_tag_i   (tag),
        .wr_data_i  (arr_wdata)
    );

    // done_q marks the cycle right after a transaction completes. The stalled
    // instruction is still presented on the inputs in that cycle, so it must
    // be allowed to retire without starting a second transaction.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (!done_q) begin
                        if (wr_en_i) begin
                            state_q     <= WRITE;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= word_addr;
                            mem_wdata_q <= data_i;
                        end else if (rd_en_i && !hit) begin
                            state_q    <= FILL;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= word_addr;
                        end
                    end
                end
                FILL, WRITE: begin
                    if (mem_ack_i) begin
                        state_q   <= IDLE;
                        done_q    <= 1'b1;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Stall and load data are combinational so a miss stalls in the same
    // cycle and a hit costs no cycles; both are forced low while in reset.
    always_comb begin
        stall_o = 1'b0;
        data_o  = '0;
        if (rst_ni) begin
            if (state_q == IDLE) begin
                stall_o = !done_q && (wr_en_i || (rd_en_i && !hit));
                if (load && hit) begin
                    data_o = line_data;
                end
            end else begin
                stall_o = 1'b1;
            end
        end
    end

    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign state_o     = state_q;

`ifdef DATA_CACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;
    logic        hit_evt;
    logic        miss_evt;

    // The retire cycle after a fill is the same load, not a new hit.
    assign hit_evt  = (state_q == IDLE) && !done_q && load && hit;
    assign miss_evt = (state_q == FILL) && mem_ack_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_evt && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_evt && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;

  logic        clk;
  logic        rst_ni;
  logic        rd_en, wr_en, mem_ack;
  logic [31:0] addr, wdata, mem_rdata;
  logic [31:0] data_o, mem_addr_o, mem_wdata_o;
  logic        stall_o, mem_req_o, mem_we_o;
  logic [1:0]  state_o;
`ifdef DATA_CACHE_STATS_EN
  logic [31:0] hit_cnt_o, miss_cnt_o;
`endif

  int tests;
  int failed;

  data_cache dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .rd_en_i     (rd_en),
    .wr_en_i     (wr_en),
    .addr_i      (addr),
    .data_i      (wdata),
    .data_o      (data_o),
    .stall_o     (stall_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata),
    .mem_ack_i   (mem_ack),
    .state_o     (state_o)
`ifdef DATA_CACHE_STATS_EN
    ,
    .hit_cnt_o   (hit_cnt_o),
    .miss_cnt_o  (miss_cnt_o)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // one vector = one clock cycle: inputs driven after posedge, outputs checked at negedge
  typedef struct {
    logic        rd, wr;
    logic [31:0] addr, data;
    logic        ack;
    logic [31:0] rdata;
    logic        stall, req, we;
    logic [31:0] maddr, mwdata, dout;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                     input logic ack, input logic [31:0] rdat,
                     input logic stall, input logic req, input logic we,
                     input logic [31:0] maddr, input logic [31:0] mwdata, input logic [31:0] dout);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.data = d; v.ack = ack; v.rdata = rdat;
    v.stall = stall; v.req = req; v.we = we; v.maddr = maddr; v.mwdata = mwdata; v.dout = dout;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input logic ack, input logic [31:0] rdat);
    rd_en = rd; wr_en = wr; addr = a; wdata = d; mem_ack = ack; mem_rdata = rdat;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    failed = 0;
    rst_ni = 1'b0;
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0);

    // ---------------- stimulus table ----------------
    //   rd wr addr          data          ack rdata         stall req we maddr       mwdata        dout
    // miss on 0x40, fill with DEADBEEF, next cycle hits
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 1, 0, 32'h40,  32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 32'h40,  32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF);
    add(0, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF);
    // conflict: 0x440 same set, new tag; then 0x40 misses again (ack in FILL entry cycle)
    add(1, 0, 32'h440, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h440, 32'h0,        0, 32'h0,        1, 1, 0, 32'h440, 32'h0,        32'h0);
    add(1, 0, 32'h440, 32'h0,        1, 32'hCAFE0440, 1, 1, 0, 32'h440, 32'h0,        32'h0);
    add(1, 0, 32'h440, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hCAFE0440);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        1, 32'hDEADBEEF, 1, 1, 0, 32'h40,  32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hDEADBEEF);
    // store hit to 0x40
    add(0, 1, 32'h40,  32'h12345678, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(0, 1, 32'h40,  32'h12345678, 0, 32'h0,        1, 1, 1, 32'h40,  32'h12345678, 32'h0);
    add(0, 1, 32'h40,  32'h12345678, 1, 32'h0,        1, 1, 1, 32'h40,  32'h12345678, 32'h0);
    add(0, 1, 32'h40,  32'h12345678, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h40,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h12345678);
    // store miss to 0x80 (no allocate), then read misses
    add(0, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(0, 1, 32'h80,  32'hA5A5A5A5, 1, 32'h0,        1, 1, 1, 32'h80,  32'hA5A5A5A5, 32'h0);
    add(0, 1, 32'h80,  32'hA5A5A5A5, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        1, 32'hA5A5A5A5, 1, 1, 0, 32'h80,  32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'hA5A5A5A5);
    // rd and wr both high act as a store
    add(1, 1, 32'h80,  32'h0BADF00D, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 1, 32'h80,  32'h0BADF00D, 1, 32'h0,        1, 1, 1, 32'h80,  32'h0BADF00D, 32'h0);
    add(1, 1, 32'h80,  32'h0BADF00D, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0BADF00D);
    // ack while idle is ignored; unaligned load hits the same word
    add(0, 0, 32'h80,  32'h0,        1, 32'hFFFFFFFF, 0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0BADF00D);
    add(1, 0, 32'h83,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0BADF00D);
    // highest set (index 15)
    add(1, 0, 32'h3C,  32'h0,        0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h3C,  32'h0,        1, 32'h3C3C3C3C, 1, 1, 0, 32'h3C,  32'h0,        32'h0);
    add(1, 0, 32'h3C,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h3C3C3C3C);
    // unaligned store goes out word-aligned
    add(0, 1, 32'h82,  32'h11111111, 0, 32'h0,        1, 0, 0, 32'h0,   32'h0,        32'h0);
    add(0, 1, 32'h82,  32'h11111111, 1, 32'h0,        1, 1, 1, 32'h80,  32'h11111111, 32'h0);
    add(0, 1, 32'h82,  32'h11111111, 0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h0);
    add(1, 0, 32'h80,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h11111111);
    add(1, 0, 32'h3C,  32'h0,        0, 32'h0,        0, 0, 0, 32'h0,   32'h0,        32'h3C3C3C3C);

    // ---------------- reset state ----------------
    #12;
    check("reset stall", 32'(stall_o), 32'h0);
    check("reset mem_req", 32'(mem_req_o), 32'h0);
    check("reset mem_we", 32'(mem_we_o), 32'h0);
    check("reset mem_addr", mem_addr_o, 32'h0);
    check("reset mem_wdata", mem_wdata_o, 32'h0);
    check("reset data_o", data_o, 32'h0);
    check("reset state", 32'(state_o), 32'h0);
    @(negedge clk);
    rst_ni = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < vecs.size(); i++) begin
      next_cycle();
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].ack, vecs[i].rdata);
      @(negedge clk);
      check($sformatf("v%0d stall", i), 32'(stall_o), 32'(vecs[i].stall));
      check($sformatf("v%0d mem_req", i), 32'(mem_req_o), 32'(vecs[i].req));
      check($sformatf("v%0d data_o", i), data_o, vecs[i].dout);
      if (vecs[i].req) begin
        check($sformatf("v%0d mem_we", i), 32'(mem_we_o), 32'(vecs[i].we));
        check($sformatf("v%0d mem_addr", i), mem_addr_o, vecs[i].maddr);
      end
      if (vecs[i].we) begin
        check($sformatf("v%0d mem_wdata", i), mem_wdata_o, vecs[i].mwdata);
      end
    end

    // ---------------- reset in the middle of a fill ----------------
    next_cycle();
    drive(1, 0, 32'h100, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("abort miss stall", 32'(stall_o), 32'h1);
    next_cycle();
    check("abort fill req", 32'(mem_req_o), 32'h1);
    check("abort fill addr", mem_addr_o, 32'h100);
    check("abort fill state", 32'(state_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort rst req", 32'(mem_req_o), 32'h0);
    check("abort rst stall", 32'(stall_o), 32'h0);
    check("abort rst addr", mem_addr_o, 32'h0);
    check("abort rst state", 32'(state_o), 32'h0);
    check("abort rst data_o", data_o, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h100, 32'h0, 0, 32'h0);
    rst_ni = 1'b1;
    // late ack after reset must be ignored
    next_cycle();
    drive(0, 0, 32'h100, 32'h0, 1, 32'h99999999);
    @(negedge clk);
    check("late ack req", 32'(mem_req_o), 32'h0);
    check("late ack stall", 32'(stall_o), 32'h0);
    next_cycle();
    drive(1, 0, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("post-reset 0x40 miss", 32'(stall_o), 32'h1);
    check("post-reset 0x40 data", data_o, 32'h0);
    next_cycle();
    drive(1, 0, 32'h40, 32'h0, 1, 32'h77777777);
    @(negedge clk);
    check("refill req", 32'(mem_req_o), 32'h1);
    check("refill addr", mem_addr_o, 32'h40);
    next_cycle();
    drive(1, 0, 32'h40, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("refill retire stall", 32'(stall_o), 32'h0);
    check("refill retire data", data_o, 32'h77777777);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check($sformatf("hit%0d stall", k), 32'(stall_o), 32'h0);
      check($sformatf("hit%0d data", k), data_o, 32'h77777777);
    end
`ifdef DATA_CACHE_STATS_EN
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("miss_cnt", miss_cnt_o, 32'd1);
    check("hit_cnt", hit_cnt_o, 32'd3);
`endif
    // 0x100 was aborted by reset, so it still misses
    next_cycle();
    drive(1, 0, 32'h100, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("aborted line miss", 32'(stall_o), 32'h1);
    check("aborted line data", data_o, 32'h0);
    next_cycle();
    drive(1, 0, 32'h100, 32'h0, 1, 32'h00000100);
    next_cycle();
    drive(0, 0, 32'h0, 32'h0, 0, 32'h0);
    @(negedge clk);
    check("final idle req", 32'(mem_req_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
